mul256_op_mem: RTL

//  Parametrised successor operand memory for the mul256 family: DEPTH x OP_W-bit operand store.
//  32-bit AHB-lite-side word port and a wide operand port for the multiplier datapath share one RAM.

---
 rtl/mul256_pkg.sv | 22 ++
 rtl/mul256_op_mem_if.sv | 24 ++
 rtl/mul256_op_arb.sv | 50 +++++
 rtl/mul256_op_mem.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mul256_pkg.sv
// Shared types and sizing helpers for the mul256 operand-memory family.
package mul256_pkg;

    localparam int LANE_W = 32;

    typedef enum logic [0:0] {
        OPM_BUS = 1'b0,
        OPM_OP  = 1'b1
    } opm_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int lanes(input int w);
        return (w + LANE_W - 1) / LANE_W;
    endfunction

endpackage

// File: rtl/mul256_op_mem_if.sv
// Bus-side word port of the operand memory: request, write data and completion handshake.
interface mul256_op_mem_if
    import mul256_pkg::*;
#(
    parameter int AW = 10
);
    logic [AW-1:0]     bus_addr;
    logic [LANE_W-1:0] bus_wdata;
    logic              bus_write;
    logic              bus_read;
    logic [LANE_W-1:0] bus_rdata;
    logic              bus_ready_early;
    logic              bus_ready;

    modport master (
        output bus_addr, bus_wdata, bus_write, bus_read,
        input  bus_rdata, bus_ready_early, bus_ready
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_write, bus_read,
        output bus_rdata, bus_ready_early, bus_ready
    );
endinterface

// File: rtl/mul256_op_arb.sv
// Write-path ownership between bus and operand ports, with a starvation guard that
// hands the path back to the bus after MAX_WAIT contended cycles.
module mul256_op_arb
    import mul256_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rstn,
    input  logic bus_write,
    input  logic op_write,
    output logic op_wready,
    output logic bus_grant
);

    opm_state_t state_q, state_d;
    logic [7:0] wait_q, wait_d;

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            OPM_BUS: begin
                if (op_write && !bus_write) state_d = OPM_OP;
            end
            OPM_OP: begin
                if ((bus_write && !op_write) || wait_q == 8'(MAX_WAIT)) begin
                    state_d = OPM_BUS;
                end else if (bus_write && op_write) begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = OPM_BUS;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= OPM_BUS;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign op_wready = (state_q == OPM_OP);
    assign bus_grant = (state_q == OPM_BUS);

endmodule

// File: rtl/mul256_op_mem.sv
// DEPTH x OP_W operand store shared by a 32-bit bus word port and a full-row operand port.
// Define MUL256_OPMEM_PARITY_EN to store and check one even-parity bit per 32-bit lane.
module mul256_op_mem
    import mul256_pkg::*;
#(
    parameter  int OP_W     = 260,
    parameter  int DEPTH    = 64,
    parameter  int MAX_WAIT = 15,
    localparam int LANES    = lanes(OP_W),
    localparam int RA_W     = clog2(DEPTH),
    localparam int LB       = clog2(LANES)
) (
    input  logic              clk,
    input  logic              rstn,
    mul256_op_mem_if.slave    bus,
    input  logic              op_read,
    input  logic [RA_W-1:0]   op_raddr,
    output logic [OP_W-1:0]   op_rdata,
    input  logic [RA_W-1:0]   op_waddr,
    input  logic              op_write,
    input  logic [OP_W-1:0]   op_wdata,
    output logic              op_wready,
    output logic              par_err
);

`ifdef MUL256_OPMEM_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int SL    = LANE_W + PW;
    localparam int ROW_W = LANES * SL;
    localparam int PAD_W = LANES * LANE_W;
    localparam int AW    = RA_W + LB;

    logic [ROW_W-1:0] mem [DEPTH];

    logic              bus_grant;
    logic [RA_W-1:0]   bus_row;
    logic [LB-1:0]     bus_lane;
    logic              bus_ready_q, bus_ready_d, bus_ready_early;
    logic [LANE_W-1:0] bus_rdata_q, bus_rdata_d, bus_word;
    logic [OP_W-1:0]   op_rdata_q, op_rdata_d;
    logic              par_err_q, par_err_d;
    logic [LANES-1:0]  lane_we;
    logic [RA_W-1:0]   wr_row;
    logic [PAD_W-1:0]  wr_flat, op_flat;
    logic [ROW_W-1:0]  wr_data, op_row, bus_row_data;

    mul256_op_arb #(.MAX_WAIT(MAX_WAIT)) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .bus_write (bus.bus_write),
        .op_write  (op_write),
        .op_wready (op_wready),
        .bus_grant (bus_grant)
    );

    assign bus_row  = bus.bus_addr[AW-1:LB];
    assign bus_lane = bus.bus_addr[LB-1:0];

    assign bus_ready_early = (bus.bus_read | (bus.bus_write & bus_grant)) & ~bus_ready_q;
    assign bus_ready_d     = bus_ready_early;

    // Ports never write together: the op port needs OP ownership, the bus commit needs BUS.
    always_comb begin
        lane_we = '0;
        wr_row  = op_waddr;
        wr_flat = PAD_W'(op_wdata);
        wr_data = '0;
        if (op_write && op_wready) begin
            lane_we = '1;
        end else if (bus.bus_write && bus_ready_q && bus_grant) begin
            wr_row  = bus_row;
            wr_flat = {LANES{bus.bus_wdata}};
            for (int l = 0; l < LANES; l++) lane_we[l] = (bus_lane == LB'(l));
        end
        for (int i = OP_W; i < PAD_W; i++) wr_flat[i] = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            wr_data[l*SL +: LANE_W] = wr_flat[l*LANE_W +: LANE_W];
`ifdef MUL256_OPMEM_PARITY_EN
            wr_data[l*SL + LANE_W] = ^wr_flat[l*LANE_W +: LANE_W];
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (lane_we[l]) mem[wr_row][l*SL +: SL] <= wr_data[l*SL +: SL];
        end
    end

    assign op_row       = mem[op_raddr];
    assign bus_row_data = mem[bus_row];

    // Lanes at or beyond LANES match no select and read back as zero.
    always_comb begin
        op_flat  = '0;
        bus_word = '0;
        for (int l = 0; l < LANES; l++) begin
            op_flat[l*LANE_W +: LANE_W] = op_row[l*SL +: LANE_W];
            if (bus_lane == LB'(l)) bus_word = bus_row_data[l*SL +: LANE_W];
        end
    end

    generate
        if (PAD_W > OP_W) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^op_flat[PAD_W-1:OP_W];
        end
    endgenerate

`ifdef MUL256_OPMEM_PARITY_EN
    logic op_bad, bus_bad;
    always_comb begin
        op_bad  = 1'b0;
        bus_bad = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            op_bad = op_bad | (^op_row[l*SL +: SL]);
            if (bus_lane == LB'(l)) bus_bad = ^bus_row_data[l*SL +: SL];
        end
        par_err_d = par_err_q | (op_read & op_bad) | (bus.bus_read & ~bus_ready_q & bus_bad);
    end
`else
    assign par_err_d = 1'b0;
`endif

    always_comb begin
        bus_rdata_d = bus_rdata_q;
        op_rdata_d  = op_rdata_q;
        if (bus.bus_read && !bus_ready_q) bus_rdata_d = bus_word;
        if (op_read) op_rdata_d = op_flat[OP_W-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_ready_q <= 1'b0;
            bus_rdata_q <= '0;
            op_rdata_q  <= '0;
            par_err_q   <= 1'b0;
        end else begin
            bus_ready_q <= bus_ready_d;
            bus_rdata_q <= bus_rdata_d;
            op_rdata_q  <= op_rdata_d;
            par_err_q   <= par_err_d;
        end
    end

    assign bus.bus_ready_early = bus_ready_early;
    assign bus.bus_ready       = bus_ready_q;
    assign bus.bus_rdata       = bus_rdata_q;
    assign op_rdata            = op_rdata_q;
    assign par_err             = par_err_q;

endmodule
